// File: rtl/whack_pkg.sv
// Shared constants, FSM encoding and small helpers for the whack-a-mole click path.
package whack_pkg;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

  localparam logic [11:0] X_MAX = 12'(SCREEN_W - 1);
  localparam logic [11:0] Y_MAX = 12'(SCREEN_H - 1);

  localparam logic [3:0] CELL_NONE = 4'd15;

  localparam int GRID_X0_DEF        = 100;
  localparam int GRID_Y0_DEF        = 60;
  localparam int CELL_W_DEF         = 200;
  localparam int CELL_H_DEF         = 160;
  localparam int HOLDOFF_FRAMES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EMIT    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  // row*3+col built from shifts and adds so no multiplier is inferred
  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/click_event.sv
// Turns a left-button press into a single click pulse with clamped coordinates and
// the 3x3 grid cell hit, then ignores the button for a number of video frames.
module click_event
  import whack_pkg::*;
#(
  parameter int GRID_X0        = GRID_X0_DEF,
  parameter int GRID_Y0        = GRID_Y0_DEF,
  parameter int CELL_W         = CELL_W_DEF,
  parameter int CELL_H         = CELL_H_DEF,
  parameter int HOLDOFF_FRAMES = HOLDOFF_FRAMES_DEF
) (
  input  logic        clk40,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  input  logic        vblnk,
  output logic        click,
  output logic [11:0] click_x,
  output logic [11:0] click_y,
  output logic [3:0]  click_cell
);

  localparam logic [12:0] XB0 = 13'(GRID_X0);
  localparam logic [12:0] XB1 = 13'(GRID_X0 + CELL_W);
  localparam logic [12:0] XB2 = 13'(GRID_X0 + 2 * CELL_W);
  localparam logic [12:0] XB3 = 13'(GRID_X0 + 3 * CELL_W);
  localparam logic [12:0] YB0 = 13'(GRID_Y0);
  localparam logic [12:0] YB1 = 13'(GRID_Y0 + CELL_H);
  localparam logic [12:0] YB2 = 13'(GRID_Y0 + 2 * CELL_H);
  localparam logic [12:0] YB3 = 13'(GRID_Y0 + 3 * CELL_H);

  localparam logic [3:0] HOLD_TARGET = 4'(HOLDOFF_FRAMES);
  localparam logic [1:0] FILL_DONE   = 2'd2;

  logic        left_s;
  logic [1:0]  fill_reg;
  logic        left_prev_reg;
  logic        vblnk_prev_reg;
  state_t      state_reg, state_next;
  logic [3:0]  frame_cnt_reg, frame_cnt_next;
  logic        click_reg;
  logic [11:0] click_x_reg, click_y_reg;
  logic [3:0]  click_cell_reg;

  logic        rise;
  logic        vblnk_rise;
  logic [11:0] clamp_x, clamp_y;
  logic [12:0] cx, cy;
  logic        col_ok, row_ok;
  logic [1:0]  col, row;
  logic [3:0]  cell_calc;

  sync_2ff u_sync (
    .clk (clk40),
    .rst (rst),
    .d   (left),
    .q   (left_s)
  );

  // left_prev starts high and only tracks left_s once the synchronizer has
  // filled, so a button held through reset never looks like a fresh press.
  assign rise       = (fill_reg == FILL_DONE) && left_s && !left_prev_reg;
  assign vblnk_rise = vblnk && !vblnk_prev_reg;

  assign clamp_x = (xpos > X_MAX) ? X_MAX : xpos;
  assign clamp_y = (ypos > Y_MAX) ? Y_MAX : ypos;

  assign cx     = {1'b0, click_x_reg};
  assign cy     = {1'b0, click_y_reg};
  assign col_ok = (cx >= XB0) && (cx < XB3);
  assign row_ok = (cy >= YB0) && (cy < YB3);
  assign col    = (cx < XB1) ? 2'd0 : ((cx < XB2) ? 2'd1 : 2'd2);
  assign row    = (cy < YB1) ? 2'd0 : ((cy < YB2) ? 2'd1 : 2'd2);
  assign cell_calc = (col_ok && row_ok) ? cell_index(row, col) : CELL_NONE;

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      IDLE:    if (rise) state_next = CAPTURE;
      CAPTURE: state_next = EMIT;
      EMIT:    state_next = (HOLDOFF_FRAMES == 0) ? IDLE : HOLDOFF;
      HOLDOFF: begin
        if (vblnk_rise) begin
          if (frame_cnt_reg + 4'd1 == HOLD_TARGET) begin
            frame_cnt_next = 4'd0;
            state_next     = IDLE;
          end else begin
            frame_cnt_next = frame_cnt_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk40) begin
    if (rst) begin
      fill_reg       <= 2'd0;
      left_prev_reg  <= 1'b1;
      vblnk_prev_reg <= 1'b0;
      state_reg      <= IDLE;
      frame_cnt_reg  <= 4'd0;
      click_reg      <= 1'b0;
      click_x_reg    <= 12'd0;
      click_y_reg    <= 12'd0;
      click_cell_reg <= CELL_NONE;
    end else begin
      if (fill_reg != FILL_DONE) fill_reg <= fill_reg + 2'd1;
      else                       left_prev_reg <= left_s;
      vblnk_prev_reg <= vblnk;
      state_reg      <= state_next;
      frame_cnt_reg  <= frame_cnt_next;
      click_reg      <= (state_reg == CAPTURE);
      if (state_reg == IDLE && rise) begin
        click_x_reg <= clamp_x;
        click_y_reg <= clamp_y;
      end
      if (state_reg == CAPTURE) click_cell_reg <= cell_calc;
    end
  end

  assign click      = click_reg;
  assign click_x    = click_x_reg;
  assign click_y    = click_y_reg;
  assign click_cell = click_cell_reg;

endmodule

// File: tb/tb_click_event.sv
// Self-checking bench for click_event: directed grid/clamp/holdoff/reset scenarios plus
// randomized presses checked against an arithmetic model of the click rules.
module tb_click_event;

  localparam int X0   = 100;
  localparam int Y0   = 60;
  localparam int W    = 200;
  localparam int H    = 160;
  localparam int HOLD = 4;

  logic        clk40 = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        left, vblnk;
  logic        click;
  logic [11:0] click_x, click_y;
  logic [3:0]  click_cell;

  int errors = 0;
  int checks = 0;
  int frames_since;
  int exp_x, exp_y, exp_cell;

  always #5 clk40 = ~clk40;

  click_event dut (
    .clk40      (clk40),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .left       (left),
    .vblnk      (vblnk),
    .click      (click),
    .click_x    (click_x),
    .click_y    (click_y),
    .click_cell (click_cell)
  );

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int model_cell(input int x, input int y);
    if (x < X0 || x >= X0 + 3 * W || y < Y0 || y >= Y0 + 3 * H) return 15;
    return ((y - Y0) / H) * 3 + (x - X0) / W;
  endfunction

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      @(posedge clk40); #1 vblnk = 1'b1;
      repeat (2) @(posedge clk40);
      #1 vblnk = 1'b0;
      repeat (5) @(posedge clk40);
      frames_since++;
    end
  endtask

  // Press at (x,y) with left first sampled high at the next edge; the model expects
  // a pulse exactly after the fourth edge when the holdoff has expired.
  task automatic press(input int x, input int y, input string name);
    logic [7:0]  seen;
    logic [7:0]  want;
    bit          exp_click;
    logic [11:0] got_x, got_y;
    logic [3:0]  got_cell;
    seen      = '0;
    exp_click = (frames_since >= HOLD);
    want      = exp_click ? 8'b0000_1000 : 8'b0000_0000;
    got_x = click_x; got_y = click_y; got_cell = click_cell;
    @(posedge clk40); #1;
    xpos = 12'(x); ypos = 12'(y); left = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk40); @(negedge clk40);
      seen[i-1] = click;
      if (i == 4) begin got_x = click_x; got_y = click_y; got_cell = click_cell; end
    end
    if (exp_click) begin
      exp_x        = clamp(x, 799);
      exp_y        = clamp(y, 599);
      exp_cell     = model_cell(exp_x, exp_y);
      frames_since = 0;
    end else begin
      got_x = click_x; got_y = click_y; got_cell = click_cell;
    end
    checks++;
    if (seen !== want) begin
      errors++;
      $display("FAIL %s pulse: got %b want %b", name, seen, want);
    end
    checks++;
    if (got_x !== 12'(exp_x) || got_y !== 12'(exp_y) || got_cell !== 4'(exp_cell)) begin
      errors++;
      $display("FAIL %s coords: got x=%0d y=%0d cell=%0d want x=%0d y=%0d cell=%0d",
               name, got_x, got_y, got_cell, exp_x, exp_y, exp_cell);
    end
    $display("press %s x=%0d y=%0d click=%b cell=%0d", name, x, y, seen, got_cell);
    @(posedge clk40); #1 left = 1'b0;
    repeat (5) @(posedge clk40);
  endtask

  task automatic test_reset();
    rst = 1'b1; left = 1'b0; vblnk = 1'b0; xpos = '0; ypos = '0;
    repeat (3) @(posedge clk40);
    @(negedge clk40);
    checks++;
    if (click !== 1'b0 || click_x !== 12'd0 || click_y !== 12'd0 || click_cell !== 4'd15) begin
      errors++;
      $display("FAIL reset_values: got click=%b x=%0d y=%0d cell=%0d want 0 0 0 15",
               click, click_x, click_y, click_cell);
    end
    #1 rst = 1'b0;
    exp_x = 0; exp_y = 0; exp_cell = 15; frames_since = HOLD;
    repeat (5) @(posedge clk40);
    $display("reset done");
  endtask

  task automatic test_grid();
    press(150, 100, "cell0");
    frames(HOLD);
    press(650, 500, "cell8");
    frames(HOLD);
    press(50, 300, "left_outside");
    frames(HOLD);
    press(900, 700, "clamp");
    frames(HOLD);
    press(499, 379, "edge_cell4");
    frames(HOLD);
    press(700, 540, "right_bottom_edge");
    frames(HOLD);
  endtask

  task automatic test_holdoff();
    press(400, 300, "hold_first");
    frames(2);
    press(450, 350, "hold_blocked");
    frames(3);
    press(450, 350, "hold_released");
    frames(HOLD);
  endtask

  task automatic test_reset_abort();
    logic [11:0] seen;
    seen = '0;
    @(posedge clk40); #1;
    xpos = 12'd300; ypos = 12'd200; left = 1'b1;
    repeat (3) @(posedge clk40);
    #1 rst = 1'b1;
    @(posedge clk40); #1 rst = 1'b0;
    exp_x = 0; exp_y = 0; exp_cell = 15; frames_since = HOLD;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk40);
      seen[i] = click;
    end
    checks++;
    if (seen !== 12'd0) begin
      errors++;
      $display("FAIL abort_no_click: got %b want 000000000000", seen);
    end
    checks++;
    if (click_cell !== 4'd15 || click_x !== 12'd0) begin
      errors++;
      $display("FAIL abort_outputs: got cell=%0d x=%0d want cell=15 x=0", click_cell, click_x);
    end
    $display("abort held=%b cell=%0d", seen, click_cell);
    @(posedge clk40); #1 left = 1'b0;
    repeat (5) @(posedge clk40);
    press(300, 200, "repress_after_reset");
    frames(HOLD);
  endtask

  task automatic test_random();
    int x, y;
    for (int n = 0; n < 24; n++) begin
      x = int'($urandom_range(0, 1023));
      y = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) x = X0 + W * int'($urandom_range(0, 3)) - int'($urandom_range(0, 1));
      frames(int'($urandom_range(0, 6)));
      press(x, y, "random");
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_grid();
    test_holdoff();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
